tlink_acquire_arb: RTL

Parametrised N-client TileLink Acquire arbiter with Grant return routing. It sits between N client ports (L1 caches, IO bridges) and one manager-side TileLink port. It merges Acquire traffic with round-robin fairness and keeps a multi-beat Acquire atomic. The winning client index is tagged into the upper bits of `client_xact_id`, so each returning Grant is demultiplexed back to its originating client.

---
 rtl/tlink_acquire_arb.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/tlink_acquire_arb.sv
// N-client TileLink Acquire arbiter (round-robin, multi-beat lock) with Grant demux by tagged xact id.
// Optional macro TLINK_ACQ_ARB_OUTREG_EN inserts a 2-entry skid buffer on the manager Acquire output.
module tlink_acquire_arb #(
  parameter int unsigned N_CLIENTS = 4,
  parameter int unsigned IDX_W     = $clog2(N_CLIENTS),
  parameter int unsigned XACT_W    = 5,
  parameter int unsigned PAY_W     = 180,
  parameter int unsigned GPAY_W    = 140,
  parameter int unsigned BEATS     = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [N_CLIENTS-1:0]        c_acq_valid,
  output logic [N_CLIENTS-1:0]        c_acq_ready,
  input  logic [N_CLIENTS*XACT_W-1:0] c_acq_xact,
  input  logic [N_CLIENTS-1:0]        c_acq_hasdata,
  input  logic [N_CLIENTS*PAY_W-1:0]  c_acq_pay,
  output logic                        m_acq_valid,
  input  logic                        m_acq_ready,
  output logic [XACT_W+IDX_W-1:0]     m_acq_xact,
  output logic                        m_acq_hasdata,
  output logic [PAY_W-1:0]            m_acq_pay,
  input  logic                        m_gnt_valid,
  output logic                        m_gnt_ready,
  input  logic [XACT_W+IDX_W-1:0]     m_gnt_xact,
  input  logic [GPAY_W-1:0]           m_gnt_pay,
  output logic [N_CLIENTS-1:0]        c_gnt_valid,
  input  logic [N_CLIENTS-1:0]        c_gnt_ready,
  output logic [XACT_W-1:0]           c_gnt_xact,
  output logic [GPAY_W-1:0]           c_gnt_pay,
  output logic                        err_badidx
);

  localparam int unsigned CNT_W = $clog2(BEATS) + 1;
  localparam int unsigned MX_W  = XACT_W + IDX_W;

  logic [IDX_W-1:0]  rr_ptr, lock_idx, hold_idx, search, win, cand;
  logic              lock, hold, found;
  logic [CNT_W-1:0]  beat_cnt;
  logic              arb_valid, arb_ready, arb_fire, sel_hd;
  logic [XACT_W-1:0] sel_xact;
  logic [PAY_W-1:0]  sel_pay;
  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_bad;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] p);
    return (32'(p) == N_CLIENTS - 1) ? '0 : p + IDX_W'(1);
  endfunction

  // Round-robin search; a stalled offer or an open multi-beat lock pins the winner.
  always_comb begin
    found  = 1'b0;
    search = rr_ptr;
    cand   = rr_ptr;
    for (int k = 0; k < int'(N_CLIENTS); k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % int'(N_CLIENTS));
      if (!found && c_acq_valid[cand]) begin
        found  = 1'b1;
        search = cand;
      end
    end
    if (hold)      win = hold_idx;
    else if (lock) win = lock_idx;
    else           win = search;
  end

  always_comb begin
    arb_valid   = 1'b0;
    sel_hd      = 1'b0;
    sel_xact    = '0;
    sel_pay     = '0;
    c_acq_ready = '0;
    for (int i = 0; i < int'(N_CLIENTS); i++) begin
      if (win == IDX_W'(i)) begin
        arb_valid      = c_acq_valid[i];
        sel_hd         = c_acq_hasdata[i];
        sel_xact       = c_acq_xact[i*XACT_W +: XACT_W];
        sel_pay        = c_acq_pay[i*PAY_W +: PAY_W];
        c_acq_ready[i] = arb_ready;
      end
    end
  end

  assign arb_fire = arb_valid & arb_ready;

  // Arbitration state: pointer, multi-beat lock, stall hold, sticky bad-index flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr     <= '0;
      lock       <= 1'b0;
      lock_idx   <= '0;
      beat_cnt   <= '0;
      hold       <= 1'b0;
      hold_idx   <= '0;
      err_badidx <= 1'b0;
    end else begin
      if (arb_fire) begin
        if (lock) begin
          if (beat_cnt == CNT_W'(BEATS - 1)) begin
            lock     <= 1'b0;
            beat_cnt <= '0;
            rr_ptr   <= next_idx(lock_idx);
          end else begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
        end else if (sel_hd && (BEATS > 1)) begin
          lock     <= 1'b1;
          lock_idx <= win;
          beat_cnt <= CNT_W'(1);
        end else begin
          rr_ptr <= next_idx(win);
        end
      end
      if (arb_valid && !arb_ready) begin
        hold     <= 1'b1;
        hold_idx <= win;
      end else if (arb_fire) begin
        hold <= 1'b0;
      end
      if (m_gnt_valid && gnt_bad) err_badidx <= 1'b1;
    end
  end

`ifdef TLINK_ACQ_ARB_OUTREG_EN
  logic [MX_W-1:0]  q_xact [2];
  logic [PAY_W-1:0] q_pay  [2];
  logic [1:0]       q_hd;
  logic [1:0]       q_cnt;
  logic             q_wr, q_rd, q_pop;

  assign arb_ready     = (q_cnt != 2'd2);
  assign m_acq_valid   = (q_cnt != 2'd0);
  assign m_acq_xact    = q_xact[q_rd];
  assign m_acq_hasdata = q_hd[q_rd];
  assign m_acq_pay     = q_pay[q_rd];
  assign q_pop         = m_acq_valid & m_acq_ready;

  // Two-entry skid buffer: client ready depends only on occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      q_cnt <= '0;
      q_wr  <= 1'b0;
      q_rd  <= 1'b0;
      q_hd  <= '0;
      for (int e = 0; e < 2; e++) begin
        q_xact[e] <= '0;
        q_pay[e]  <= '0;
      end
    end else begin
      if (arb_fire) begin
        q_xact[q_wr] <= {win, sel_xact};
        q_pay[q_wr]  <= sel_pay;
        q_hd[q_wr]   <= sel_hd;
        q_wr         <= ~q_wr;
      end
      if (q_pop) q_rd <= ~q_rd;
      case ({arb_fire, q_pop})
        2'b10:   q_cnt <= q_cnt + 2'd1;
        2'b01:   q_cnt <= q_cnt - 2'd1;
        default: q_cnt <= q_cnt;
      endcase
    end
  end
`else
  assign arb_ready     = m_acq_ready;
  assign m_acq_valid   = arb_valid;
  assign m_acq_xact    = {win, sel_xact};
  assign m_acq_hasdata = sel_hd;
  assign m_acq_pay     = sel_pay;
`endif

  // Grant demux on the tag bits; an out-of-range tag is drained and flagged.
  assign gnt_idx    = m_gnt_xact[MX_W-1:XACT_W];
  assign c_gnt_xact = m_gnt_xact[XACT_W-1:0];
  assign c_gnt_pay  = m_gnt_pay;

  always_comb begin
    gnt_bad     = 1'b1;
    c_gnt_valid = '0;
    m_gnt_ready = 1'b1;
    for (int i = 0; i < int'(N_CLIENTS); i++) begin
      if (gnt_idx == IDX_W'(i)) begin
        gnt_bad        = 1'b0;
        c_gnt_valid[i] = m_gnt_valid;
        m_gnt_ready    = c_gnt_ready[i];
      end
    end
  end

endmodule
